// File: rtl/pipelined_cla_adder_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pkg_arith
// Description : Shared defaults and configuration helpers for the pipelined
//               carry-lookahead adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package pkg_arith;

    localparam int GRP_DEFAULT   = 4;
    localparam int WIDTH_DEFAULT = 16;

    // Number of lookahead groups, which is also the pipeline depth
    function automatic int calc_ng(input int width, input int grp);
        return width / grp;
    endfunction

    // Group size must be one of the supported lookahead widths and must tile WIDTH exactly
    function automatic bit cfg_legal(input int width, input int grp);
        return ((grp == 2) || (grp == 4) || (grp == 8)) && (width > 0) && ((width % grp) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_cla_adder_cla_group.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : cla_group
// Description : GRP-bit combinational carry-lookahead group. Produces the sum,
//               the group carry-out and the carry into the top bit.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_group #(
    parameter int GRP = 4
) (
    input  logic [GRP-1:0] a,
    input  logic [GRP-1:0] b,
    input  logic           ci,
    output logic [GRP-1:0] s,
    output logic           co,
    output logic           c_msb
);

    logic [GRP-1:0] p;
    logic [GRP-1:0] g;
    logic [GRP:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // Every carry is a flat OR of generate terms, each gated by all propagates above it
    always_comb begin
        logic term;
        c    = '0;
        term = 1'b0;
        for (int i = 0; i <= GRP; i++) begin
            term = ci;
            for (int j = 0; j < i; j++) begin
                term = term & p[j];
            end
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) begin
                    term = term & p[m];
                end
                c[i] = c[i] | term;
            end
        end
    end

    assign s     = p ^ c[GRP-1:0];
    assign co    = c[GRP];
    assign c_msb = c[GRP-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pipelined_cla_adder
// Description : Pipelined carry-lookahead adder/subtractor. One GRP-bit group
//               per stage, carry rippled between stages through registers,
//               valid/ready handshake with whole-pipeline stall.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_cla_adder
    import pkg_arith::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int GRP   = GRP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = calc_ng(WIDTH, GRP);

    if (!cfg_legal(WIDTH, GRP)) begin : g_cfg_check
        $error("pipelined_cla_adder: WIDTH must be a multiple of GRP and GRP must be 2, 4 or 8");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c_in0;

    // Subtraction is a + ~b + 1, so the incoming carry is forced high in that mode
    assign b_eff = sub ? ~b : b;
    assign c_in0 = sub | cin;

    // The whole pipeline moves as one unit unless a held result is being refused
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NG; k++) begin : g_stage
        localparam int HI = (k + 1) * GRP;

        logic [GRP-1:0] grp_a;
        logic [GRP-1:0] grp_b;
        logic [GRP-1:0] grp_s;
        logic           grp_ci;
        logic           grp_co;
        logic           grp_cmsb;
        logic           v_in;
        logic [HI-1:0]  sum_d;
        logic [HI-1:0]  sum_q;
        logic           co_q;
        logic           valid_q;

        if (k == 0) begin : g_src_in
            assign grp_a  = a[GRP-1:0];
            assign grp_b  = b_eff[GRP-1:0];
            assign grp_ci = c_in0;
            assign v_in   = in_valid;
            assign sum_d  = grp_s;
        end else begin : g_src_prev
            assign grp_a  = g_stage[k-1].g_fwd.a_rem_q[GRP-1:0];
            assign grp_b  = g_stage[k-1].g_fwd.b_rem_q[GRP-1:0];
            assign grp_ci = g_stage[k-1].co_q;
            assign v_in   = g_stage[k-1].valid_q;
            assign sum_d  = {grp_s, g_stage[k-1].sum_q};
        end

        cla_group #(
            .GRP   (GRP)
        ) u_group (
            .a     (grp_a),
            .b     (grp_b),
            .ci    (grp_ci),
            .s     (grp_s),
            .co    (grp_co),
            .c_msb (grp_cmsb)
        );

        // Stage valid shifts on every advance so bubbles travel like real entries
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
            end else if (adv) begin
                valid_q <= v_in;
            end
        end

        if (k < NG - 1) begin : g_fwd
            localparam int REM = WIDTH - HI;

            logic [REM-1:0] a_rem_d;
            logic [REM-1:0] b_rem_d;
            logic [REM-1:0] a_rem_q;
            logic [REM-1:0] b_rem_q;

            if (k == 0) begin : g_rem_in
                assign a_rem_d = a[WIDTH-1:HI];
                assign b_rem_d = b_eff[WIDTH-1:HI];
            end else begin : g_rem_prev
                assign a_rem_d = g_stage[k-1].g_fwd.a_rem_q[REM+GRP-1:GRP];
                assign b_rem_d = g_stage[k-1].g_fwd.b_rem_q[REM+GRP-1:GRP];
            end

            // Intermediate stage: partial sum, group carry and still-unused operand bits
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q   <= '0;
                    co_q    <= 1'b0;
                    a_rem_q <= '0;
                    b_rem_q <= '0;
                end else if (adv) begin
                    sum_q   <= sum_d;
                    co_q    <= grp_co;
                    a_rem_q <= a_rem_d;
                    b_rem_q <= b_rem_d;
                end
            end
        end else begin : g_last
            logic ovf_q;
            logic zero_q;

            // Final stage loads only real results so the outputs hold across bubbles
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q  <= '0;
                    co_q   <= 1'b0;
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv && v_in) begin
                    sum_q  <= sum_d;
                    co_q   <= grp_co;
                    ovf_q  <= grp_co ^ grp_cmsb;
                    zero_q <= (sum_d == '0);
                end
            end
        end
    end

    assign out_valid = g_stage[NG-1].valid_q;
    assign s         = g_stage[NG-1].sum_q;
    assign cout      = g_stage[NG-1].co_q;
    assign ovf       = g_stage[NG-1].g_last.ovf_q;
    assign zero      = g_stage[NG-1].g_last.zero_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pipelined_cla_adder
// Description : Self-checking bench for pipelined_cla_adder (WIDTH=16, GRP=4)
//               with an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_cla_adder;

    localparam int W  = 16;
    localparam int G  = 4;
    localparam int NG = 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    localparam int ND = 7;
    localparam logic [W-1:0] DA [ND] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h0007, 16'h0FFF, 16'hFFFF, 16'h8000};
    localparam logic [W-1:0] DB [ND] = '{16'h0001, 16'h0001, 16'h0007, 16'h0005, 16'h0000, 16'hFFFF, 16'h0001};
    localparam logic         DC [ND] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic         DU [ND] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam res_t         DR [ND] = '{
        '{16'h0000, 1'b1, 1'b0, 1'b1},
        '{16'h8000, 1'b0, 1'b1, 1'b0},
        '{16'hFFFE, 1'b0, 1'b0, 1'b0},
        '{16'h0002, 1'b1, 1'b0, 1'b0},
        '{16'h1000, 1'b0, 1'b0, 1'b0},
        '{16'hFFFF, 1'b1, 1'b0, 1'b0},
        '{16'h7FFF, 1'b1, 1'b1, 1'b0}
    };

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         cin       = 1'b0;
    logic         sub       = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipelined_cla_adder #(
        .WIDTH     (W),
        .GRP       (G)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    // Reference: plain modular arithmetic; overflow from operand/result signs
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb);
        logic [W:0]   full;
        logic [W-1:0] ye;
        logic         c0;
        res_t         r;
        ye     = sb ? ~y : y;
        c0     = sb ? 1'b1 : ci;
        full   = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, c0};
        r.s    = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (x[W-1] == ye[W-1]) && (r.s[W-1] != x[W-1]);
        r.zero = (r.s == '0);
        return r;
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom());
        endcase
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        total++;
        if ({s, cout, ovf, zero} !== 19'd0) begin
            bad++;
            $display("FAIL reset_outputs: got s=%h cout=%b ovf=%b zero=%b want all 0", s, cout, ovf, zero);
        end
        #2 rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        res_t got;
        for (int i = 0; i < ND; i++) begin
            @(negedge clk);
            a         = DA[i];
            b         = DB[i];
            cin       = DC[i];
            sub       = DU[i];
            in_valid  = 1'b1;
            out_ready = 1'b1;
            @(posedge clk);
            for (int k = 1; k <= NG; k++) begin
                @(negedge clk);
                in_valid = 1'b0;
                total++;
                if (out_valid !== (k == NG)) begin
                    bad++;
                    $display("FAIL directed[%0d] latency after %0d edges: out_valid=%b want %b", i, k, out_valid, (k == NG));
                end
            end
            got = {s, cout, ovf, zero};
            total++;
            if (got !== DR[i]) begin
                bad++;
                $display("FAIL directed[%0d] result: got s=%h cout=%b ovf=%b zero=%b want s=%h cout=%b ovf=%b zero=%b",
                         i, s, cout, ovf, zero, DR[i].s, DR[i].cout, DR[i].ovf, DR[i].zero);
            end
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || {s, cout, ovf, zero} !== DR[i]) begin
                bad++;
                $display("FAIL directed[%0d] bubble_hold: got valid=%b s=%h cout=%b ovf=%b zero=%b want valid=0 s=%h",
                         i, out_valid, s, cout, ovf, zero, DR[i].s);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t         exp_q[$];
        res_t         r;
        res_t         snap;
        logic [W-1:0] ca;
        logic [W-1:0] cb;
        logic         cc;
        logic         cs;
        int           sent = 0;
        int           got  = 0;
        int           cyc  = 0;
        snap = '0;
        ca = 16'($urandom()); cb = 16'($urandom()); cc = 1'($urandom()); cs = 1'($urandom());
        while (got < 8 && cyc < 200) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc <= 9);
            in_valid  = (sent < 8);
            a = ca; b = cb; cin = cc; sub = cs;
            #1;
            total++;
            if (in_ready !== (!out_valid || out_ready)) begin
                bad++;
                $display("FAIL b2b in_ready cyc %0d: got %b want %b", cyc, in_ready, (!out_valid || out_ready));
            end
            if (cyc >= 6 && cyc <= 9) begin
                total++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b stall cyc %0d: out_valid=%b in_ready=%b want 1 and 0", cyc, out_valid, in_ready);
                end
            end
            if (cyc >= 7 && cyc <= 9) begin
                total++;
                if ({s, cout, ovf, zero} !== snap) begin
                    bad++;
                    $display("FAIL b2b stall_hold cyc %0d: got s=%h cout=%b ovf=%b zero=%b want s=%h cout=%b ovf=%b zero=%b",
                             cyc, s, cout, ovf, zero, snap.s, snap.cout, snap.ovf, snap.zero);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b spurious result cyc %0d: got s=%h want none", cyc, s);
                end else begin
                    r = exp_q.pop_front();
                    if ({s, cout, ovf, zero} !== r) begin
                        bad++;
                        $display("FAIL b2b result %0d: got s=%h cout=%b ovf=%b zero=%b want s=%h cout=%b ovf=%b zero=%b",
                                 got, s, cout, ovf, zero, r.s, r.cout, r.ovf, r.zero);
                    end
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(ca, cb, cc, cs));
                sent++;
                ca = 16'($urandom()); cb = 16'($urandom()); cc = 1'($urandom()); cs = 1'($urandom());
            end
            snap = {s, cout, ovf, zero};
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (got != 8) begin
            bad++;
            $display("FAIL b2b count: got %0d results want 8", got);
        end
    endtask

    task automatic test_reset_midstream();
        res_t         r;
        logic [W-1:0] ca;
        logic [W-1:0] cb;
        logic         cc;
        logic         cs;
        int           stale = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 16'($urandom()); b = 16'($urandom()); cin = 1'($urandom()); sub = 1'($urandom());
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL midreset precondition: out_valid=%b want 1", out_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || {s, cout, ovf, zero} !== 19'd0) begin
            bad++;
            $display("FAIL midreset async clear: valid=%b s=%h cout=%b ovf=%b zero=%b want all 0", out_valid, s, cout, ovf, zero);
        end
        #1 rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset in_ready: got %b want 1", in_ready);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        total++;
        if (stale != 0) begin
            bad++;
            $display("FAIL midreset stale: got %0d cycles with out_valid=1 want 0", stale);
        end
        @(negedge clk);
        ca = pick_operand(); cb = pick_operand(); cc = 1'($urandom()); cs = 1'($urandom());
        a = ca; b = cb; cin = cc; sub = cs;
        in_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= NG; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            total++;
            if (out_valid !== (k == NG)) begin
                bad++;
                $display("FAIL midreset new-op latency after %0d edges: out_valid=%b want %b", k, out_valid, (k == NG));
            end
        end
        r = model(ca, cb, cc, cs);
        total++;
        if ({s, cout, ovf, zero} !== r) begin
            bad++;
            $display("FAIL midreset new-op result: got s=%h cout=%b ovf=%b zero=%b want s=%h cout=%b ovf=%b zero=%b",
                     s, cout, ovf, zero, r.s, r.cout, r.ovf, r.zero);
        end
        @(negedge clk);
    endtask

    task automatic test_random_stream();
        res_t         exp_q[$];
        res_t         r;
        logic [W-1:0] ca;
        logic [W-1:0] cb;
        logic         cc;
        logic         cs;
        int           sent = 0;
        int           got  = 0;
        int           cyc  = 0;
        ca = pick_operand(); cb = pick_operand(); cc = 1'($urandom()); cs = 1'($urandom());
        while (got < 60 && cyc < 1000) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < 60) && ($urandom_range(0, 9) < 7);
            a = ca; b = cb; cin = cc; sub = cs;
            #1;
            total++;
            if (in_ready !== (!out_valid || out_ready)) begin
                bad++;
                $display("FAIL rand in_ready cyc %0d: got %b want %b", cyc, in_ready, (!out_valid || out_ready));
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rand spurious result cyc %0d: got s=%h want none", cyc, s);
                end else begin
                    r = exp_q.pop_front();
                    if ({s, cout, ovf, zero} !== r) begin
                        bad++;
                        $display("FAIL rand result %0d: got s=%h cout=%b ovf=%b zero=%b want s=%h cout=%b ovf=%b zero=%b",
                                 got, s, cout, ovf, zero, r.s, r.cout, r.ovf, r.zero);
                    end
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(ca, cb, cc, cs));
                sent++;
                ca = pick_operand(); cb = pick_operand(); cc = 1'($urandom()); cs = 1'($urandom());
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (got != 60) begin
            bad++;
            $display("FAIL rand count: got %0d results want 60", got);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
        test_random_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the datapath.
- Splits a WIDTH-bit operation into GRP-bit lookahead groups, with one pipeline stage per group. The carry ripples between groups through registers.
- Adds a subtract mode, signed-overflow and zero flags, and a valid/ready handshake with full-pipeline stall.
- Used in the arithmetic units where one add per cycle at WIDTH ≥ 16 must close timing.

Parameters:
- WIDTH, 16, operand/sum width. Must be a multiple of GRP.
- GRP, 4, bits per lookahead group. Legal values: 2, 4, 8.
- NG, WIDTH/GRP, number of groups, which equals the pipeline depth. Derived; not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand set present.
- in_ready  out  1  block can accept this cycle.
- a  in  WIDTH  operand A (two's complement or unsigned).
- b  in  WIDTH  operand B.
- cin  in  1  carry in. Ignored when sub=1.
- sub  in  1  0: a+b+cin; 1: a-b (a+~b+1).
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- s  out  WIDTH  sum/difference.
- cout  out  1  carry out. In subtract mode, 1 means no borrow.
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero  out  1  s == 0.

Behaviour:
- Reset (rst_n=0, async): all stage valid bits cleared. out_valid=0, s=0, cout=0, ovf=0, zero=0. in_ready=1 as soon as reset deasserts.
- Advance enable: adv = !out_valid || out_ready.
  - All stages shift together when adv=1; all hold when adv=0.
  - in_ready = adv, a combinational function of out_valid and out_ready only. It never depends on in_valid.
- Accept: in_valid && in_ready at a rising edge. Accepted operands are never dropped or duplicated.
- Group operand: b_eff = sub ? ~b : b. Group carry-in: c_in0 = sub ? 1 : cin.
- Stage k (0..NG-1):
  - Computes group k from the registered skewed operand slice and the registered carry from stage k-1 (stage 0 uses c_in0).
  - Group logic: p=a^b_eff, g=a&b_eff. Carries by lookahead. Sum bit = p ^ carry_in_bit.
  - Registers forwarded: lower sum bits, group carry-out, the remaining higher operand slices, and the MSB carry-in (needed for ovf).
- Latency: exactly NG cycles. A transaction accepted at edge t has out_valid=1 after edge t+NG-1, provided no stall occurred.
- Throughput: one result per cycle while out_ready=1.
- Outputs are driven directly from the final-stage register. There is no combinational path from a, b, cin or sub to any output.
- Bubbles: a stage with valid=0 still shifts. Its data contents are don't-care, but s, cout, ovf and zero are held at their last values while out_valid=0.
- Stall: with out_valid=1 and out_ready=0, all outputs and all stage contents are held stable, and in_ready=0.
- Simultaneous accept and emit: allowed when out_ready=1. The pipeline shifts with no lost slot.
- Reset mid-operation: in-flight transactions are discarded. After rst_n rises, no stale result ever appears.
- Flag arithmetic:
  - zero is computed on the final WIDTH-bit s.
  - cout is the carry out of bit WIDTH-1.
  - Width wrap-around is modular (mod 2^WIDTH).

Decomposition:
- Shared package pkg_arith:
  - GRP_DEFAULT=4 and WIDTH_DEFAULT=16.
  - Function to derive NG.
  - Compile-time legality check (WIDTH % GRP == 0, GRP ∈ {2,4,8}).
- One sub-module, cla_group: GRP-bit combinational lookahead.
  - Inputs: a, b, ci.
  - Outputs: s, co, and c_msb (carry into the top bit).
  - Instantiated NG times via generate. Stage registers, skew registers and handshake live in the top level.

Test Plan (WIDTH=16, GRP=4, latency 4):
1. Add wrap: a=0xFFFF, b=0x0001, cin=0, sub=0 → after 4 cycles s=0x0000, cout=1, ovf=0, zero=1.
2. Signed overflow: a=0x7FFF, b=0x0001, add → s=0x8000, cout=0, ovf=1, zero=0.
3. Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) → s=0xFFFE, cout=0, ovf=0. Then a=0x0007, b=0x0005 → s=0x0002, cout=1.
4. Carry across every group boundary: a=0x0FFF, b=0x0000, cin=1 → s=0x1000, cout=0. Also a=0xFFFF, b=0xFFFF, cin=1 → s=0xFFFF, cout=1.
5. Back-to-back with stall: 8 random ops streamed; out_ready=0 for cycles 6–9.
   - in_ready=0 during the stall and outputs held stable.
   - All 8 results emerge in order and match the reference model; no loss or duplication.
6. Reset mid-stream: 3 ops in flight, pulse rst_n low between clock edges.
   - out_valid=0 immediately, asynchronously.
   - After release, in_ready=1, and no result appears until a new op has been accepted and 4 cycles have passed.
